ic_fill_ctl: RTL and testbench

Instruction-cache line-fill sequencer between the ICU miss logic and the BIU. On a miss it issues one bus request per line: a 4-word burst when the cache is enabled, or a single-word bypass fetch when it is not. It counts returned beats, steers each word into the instruction RAM half, forwards the missed word to the ibuffer, and writes the tag on completion. It also owns the ICU powerdown handshake with the PCSU.

---
 rtl/icu_pkg.sv | 19 +
 rtl/ic_fill_cnt.sv | 28 ++
 rtl/ic_fill_ctl.sv | 165 ++++++++++++++++
 tb/tb_ic_fill_ctl.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/icu_pkg.sv
// rtl/icu_pkg.sv - shared types and bus encodings for the I-cache line-fill sequencer
package icu_pkg;

  localparam int LINE_WORDS = 4;

  localparam logic [3:0] ICU_TYPE_LINE = 4'b0100;
  localparam logic [3:0] ICU_TYPE_NC   = 4'b0000;
  localparam logic [1:0] ICU_SIZE_LINE = 2'b11;
  localparam logic [1:0] ICU_SIZE_WORD = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_FILL,
    S_TAG,
    S_PDOWN
  } fill_state_e;

endpackage

// File: rtl/ic_fill_cnt.sv
// rtl/ic_fill_cnt.sv - beat counter with wrap adder; yields the word index of the current beat
module ic_fill_cnt #(
  parameter int LINE_WORDS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       inc,
  input  logic [1:0] start_word,
  output logic [1:0] word_addr,
  output logic       last
);

  logic [1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= 2'd0;
    end else if (inc) begin
      cnt <= cnt + 2'd1;
    end
  end

  // Two-bit add wraps naturally, giving the critical-word-first order
  assign word_addr = start_word + cnt;
  assign last      = (cnt == 2'(LINE_WORDS - 1));

endmodule

// File: rtl/ic_fill_ctl.sv
// rtl/ic_fill_ctl.sv - I-cache miss line-fill / bypass sequencer with PCSU powerdown handshake
// ICU_CWF_EN: when defined, the line burst starts at the missed word and wraps (critical word first)
module ic_fill_ctl #(
  parameter int AW         = 32,
  parameter int LINE_WORDS = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          miss_req,
  input  logic [AW-1:0] miss_addr,
  input  logic          iu_psr_ice,
  input  logic          iu_flush_e,
  input  logic          pcsu_powerdown,
  input  logic [1:0]    biu_icu_ack,
  output logic          icu_req,
  output logic [AW-1:0] icu_addr,
  output logic [3:0]    icu_type,
  output logic [1:0]    icu_size,
  output logic [1:0]    fill_word_addr,
  output logic [1:0]    icu_ram_we,
  output logic          icu_itag_we,
  output logic          icu_tag_vld,
  output logic          bypass_ack,
  output logic          fill_busy,
  output logic          fill_err,
  output logic          icu_in_powerdown
);

  import icu_pkg::*;

  fill_state_e    state, state_nxt;
  logic [AW-1:2]  addr_q;
  logic           cached_q, abort_q, err_q, pd_q;
  logic           active, beat, err, last_beat, accept;
  logic [1:0]     start_word;
  logic           addr_lsb_unused;

  assign addr_lsb_unused = ^miss_addr[1:0];

  assign active = (state == S_REQ) || (state == S_FILL);
  // A simultaneous data beat and error counts only as the error
  assign err    = active && biu_icu_ack[1];
  assign beat   = active && biu_icu_ack[0] && !biu_icu_ack[1];
  assign accept = (state == S_IDLE) && !pcsu_powerdown && miss_req;

`ifdef ICU_CWF_EN
  assign start_word = addr_q[3:2];
`else
  assign start_word = 2'b00;
`endif

  ic_fill_cnt #(
    .LINE_WORDS (LINE_WORDS)
  ) u_cnt (
    .clk        (clk),
    .reset      (reset),
    .clr        (state == S_IDLE),
    .inc        (beat),
    .start_word (start_word),
    .word_addr  (fill_word_addr),
    .last       (last_beat)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    icu_req     = 1'b0;
    icu_addr    = '0;
    icu_type    = 4'b0000;
    icu_size    = 2'b00;
    icu_ram_we  = 2'b00;
    icu_itag_we = 1'b0;
    icu_tag_vld = 1'b0;
    bypass_ack  = 1'b0;
    fill_busy   = 1'b0;
    fill_err    = err;

    case (state)
      S_IDLE: begin
        if (pcsu_powerdown) begin
          state_nxt = S_PDOWN;
        end else if (miss_req) begin
          state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        fill_busy = 1'b1;
        icu_req   = 1'b1;
        if (cached_q) begin
          icu_addr = {addr_q[AW-1:4], start_word, 2'b00};
          icu_type = ICU_TYPE_LINE;
          icu_size = ICU_SIZE_LINE;
        end else begin
          icu_addr = {addr_q, 2'b00};
          icu_type = ICU_TYPE_NC;
          icu_size = ICU_SIZE_WORD;
        end
        if (err || beat) begin
          state_nxt = !cached_q ? S_IDLE : (err ? S_TAG : S_FILL);
        end
      end
      S_FILL: begin
        fill_busy = 1'b1;
        if (err || (beat && last_beat)) begin
          state_nxt = S_TAG;
        end
      end
      S_TAG: begin
        fill_busy   = 1'b1;
        icu_itag_we = 1'b1;
        icu_tag_vld = !abort_q && !err_q;
        state_nxt   = S_IDLE;
      end
      S_PDOWN: begin
        if (!pcsu_powerdown) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    if (beat) begin
      if (cached_q && !err_q) begin
        icu_ram_we[fill_word_addr[0]] = 1'b1;
      end
      bypass_ack = !abort_q && (!cached_q || (fill_word_addr == addr_q[3:2]));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q   <= '0;
      cached_q <= 1'b0;
      abort_q  <= 1'b0;
      err_q    <= 1'b0;
      pd_q     <= 1'b0;
    end else begin
      pd_q <= (state == S_PDOWN) && pcsu_powerdown;
      if (accept) begin
        addr_q   <= miss_addr[AW-1:2];
        cached_q <= iu_psr_ice;
        abort_q  <= 1'b0;
        err_q    <= 1'b0;
      end else begin
        // A flush stops forwarding only; the burst itself must still drain
        if (fill_busy && iu_flush_e) begin
          abort_q <= 1'b1;
        end
        if (err) begin
          err_q <= 1'b1;
        end
      end
    end
  end

  assign icu_in_powerdown = pd_q;

endmodule

// File: tb/tb_ic_fill_ctl.sv
// tb/tb_ic_fill_ctl.sv - scoreboard bench for ic_fill_ctl (expectations adapt to ICU_CWF_EN)
module tb_ic_fill_ctl;

  logic        clk = 1'b0;
  logic        reset;
  logic        miss_req;
  logic [31:0] miss_addr;
  logic        iu_psr_ice;
  logic        iu_flush_e;
  logic        pcsu_powerdown;
  logic [1:0]  ack;
  logic        icu_req;
  logic [31:0] icu_addr;
  logic [3:0]  icu_type;
  logic [1:0]  icu_size;
  logic [1:0]  fill_word_addr;
  logic [1:0]  icu_ram_we;
  logic        icu_itag_we;
  logic        icu_tag_vld;
  logic        bypass_ack;
  logic        fill_busy;
  logic        fill_err;
  logic        icu_in_powerdown;

  always #5 clk = ~clk;

  ic_fill_ctl #(.AW(32), .LINE_WORDS(4)) dut (
    .clk              (clk),
    .reset            (reset),
    .miss_req         (miss_req),
    .miss_addr        (miss_addr),
    .iu_psr_ice       (iu_psr_ice),
    .iu_flush_e       (iu_flush_e),
    .pcsu_powerdown   (pcsu_powerdown),
    .biu_icu_ack      (ack),
    .icu_req          (icu_req),
    .icu_addr         (icu_addr),
    .icu_type         (icu_type),
    .icu_size         (icu_size),
    .fill_word_addr   (fill_word_addr),
    .icu_ram_we       (icu_ram_we),
    .icu_itag_we      (icu_itag_we),
    .icu_tag_vld      (icu_tag_vld),
    .bypass_ack       (bypass_ack),
    .fill_busy        (fill_busy),
    .fill_err         (fill_err),
    .icu_in_powerdown (icu_in_powerdown)
  );

`ifdef ICU_CWF_EN
  localparam logic [31:0] LINE_REQ   = 32'h0000_1008;
  localparam int          SW         = 2;
  localparam int          FWD        = 0;
  localparam int          FLUSH1_BYP = 0;
  localparam int          ERR2_BYP   = 0;
`else
  localparam logic [31:0] LINE_REQ   = 32'h0000_1000;
  localparam int          SW         = 0;
  localparam int          FWD        = 2;
  localparam int          FLUSH1_BYP = -1;
  localparam int          ERR2_BYP   = -1;
`endif

  typedef struct packed {
    logic [1:0] fwa;
    logic [1:0] we;
    logic       byp;
    logic       itag;
    logic       vld;
    logic       err;
  } ev_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  typ;
    logic [1:0]  size;
  } req_t;

  ev_t  ev_q[$];
  req_t req_q[$];
  ev_t  obs_e, exp_e;
  req_t exp_r;
  int   total = 0;
  int   bad = 0;
  logic req_seen = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic exp_req(input logic [31:0] a, input logic [3:0] t, input logic [1:0] s);
    req_q.push_back({a, t, s});
  endtask

  task automatic exp_ev(input logic [1:0] f, input logic [1:0] w, input logic b,
                        input logic t, input logic v, input logic e);
    ev_q.push_back({f, w, b, t, v, e});
  endtask

  task automatic exp_beats(input int n, input int byp_beat);
    logic [1:0] f;
    for (int i = 0; i < n; i++) begin
      f = 2'(SW + i);
      exp_ev(f, f[0] ? 2'b10 : 2'b01, i == byp_beat, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic exp_tag(input logic v);
    exp_ev(2'b00, 2'b00, 1'b0, 1'b1, v, 1'b0);
  endtask

  task automatic run_line(input logic [31:0] a, input int flush_beat, input int err_beat, input int gap);
    miss_addr  = a;
    iu_psr_ice = 1'b1;
    miss_req   = 1'b1;
    tick;
    miss_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      repeat (gap) tick;
      if (i == 0) chk("req_held", icu_req, 1);
      ack        = (i == err_beat) ? 2'b11 : 2'b01;
      iu_flush_e = (i == flush_beat);
      tick;
      ack        = 2'b00;
      iu_flush_e = 1'b0;
      if (i == 0) chk("req_drop", icu_req, 0);
      if (i == err_beat) break;
    end
    chk("tag_busy", fill_busy, 1);
    tick;
    chk("idle_busy", fill_busy, 0);
  endtask

  task automatic run_bypass(input logic [31:0] a);
    miss_addr  = a;
    iu_psr_ice = 1'b0;
    miss_req   = 1'b1;
    tick;
    miss_req = 1'b0;
    chk("byp_busy", fill_busy, 1);
    ack = 2'b01;
    tick;
    ack = 2'b00;
    chk("byp_done_busy", fill_busy, 0);
    chk("byp_done_req", icu_req, 0);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (icu_req && !req_seen) begin
        if (req_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL spurious_req: got addr 0x%0h want no request", icu_addr);
        end else begin
          exp_r = req_q.pop_front();
          chk("req_fields", {icu_addr, icu_type, icu_size}, exp_r);
        end
      end
      if (icu_ram_we != 2'b00 || bypass_ack || icu_itag_we || fill_err) begin
        obs_e.fwa  = (icu_ram_we != 2'b00) ? fill_word_addr : 2'b00;
        obs_e.we   = icu_ram_we;
        obs_e.byp  = bypass_ack;
        obs_e.itag = icu_itag_we;
        obs_e.vld  = icu_tag_vld;
        obs_e.err  = fill_err;
        if (ev_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL spurious_event: got 0x%0h want none at %0t", obs_e, $time);
        end else begin
          exp_e = ev_q.pop_front();
          chk("beat_event", obs_e, exp_e);
        end
      end
    end
    req_seen = icu_req;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset          = 1'b1;
    miss_req       = 1'b0;
    miss_addr      = 32'h0;
    iu_psr_ice     = 1'b0;
    iu_flush_e     = 1'b0;
    pcsu_powerdown = 1'b0;
    ack            = 2'b00;
    repeat (3) tick;
    chk("reset_outputs", {icu_req, icu_addr, icu_type, icu_size, fill_word_addr, icu_ram_we,
                          icu_itag_we, icu_tag_vld, bypass_ack, fill_busy, fill_err,
                          icu_in_powerdown}, 0);
    reset = 1'b0;
    tick;
    chk("post_reset_busy", fill_busy, 0);

    // zero-gap cached line fill
    exp_req(LINE_REQ, 4'b0100, 2'b11);
    exp_beats(4, FWD);
    exp_tag(1'b1);
    run_line(32'h0000_1008, -1, -1, 0);

    // same line, two idle cycles before and between beats
    exp_req(LINE_REQ, 4'b0100, 2'b11);
    exp_beats(4, FWD);
    exp_tag(1'b1);
    run_line(32'h0000_1008, -1, -1, 2);

    // reset after beat 0 returns straight to idle
    exp_req(LINE_REQ, 4'b0100, 2'b11);
    exp_beats(1, FWD);
    miss_addr  = 32'h0000_1008;
    iu_psr_ice = 1'b1;
    miss_req   = 1'b1;
    tick;
    miss_req = 1'b0;
    ack = 2'b01;
    tick;
    ack   = 2'b00;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    chk("midfill_reset_busy", fill_busy, 0);
    chk("midfill_reset_req", icu_req, 0);

    // uncached bypass fetch
    exp_req(32'h0000_2004, 4'b0000, 2'b10);
    exp_ev(2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    run_bypass(32'h0000_2006);

    // flush during beat 1
    exp_req(LINE_REQ, 4'b0100, 2'b11);
    exp_beats(4, FLUSH1_BYP);
    exp_tag(1'b0);
    run_line(32'h0000_1008, 1, -1, 0);

    // flush coincident with the forwarding beat keeps that beat
    exp_req(LINE_REQ, 4'b0100, 2'b11);
    exp_beats(4, FWD);
    exp_tag(1'b0);
    run_line(32'h0000_1008, FWD, -1, 0);

    // bus error on beat 2
    exp_req(LINE_REQ, 4'b0100, 2'b11);
    exp_beats(2, ERR2_BYP);
    exp_ev(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
    exp_tag(1'b0);
    run_line(32'h0000_1008, -1, 2, 0);

    // powerdown raised mid-fill with a new miss held pending
    exp_req(LINE_REQ, 4'b0100, 2'b11);
    exp_beats(4, FWD);
    exp_tag(1'b1);
    miss_addr  = 32'h0000_1008;
    iu_psr_ice = 1'b1;
    miss_req   = 1'b1;
    tick;
    ack = 2'b01;
    tick;
    pcsu_powerdown = 1'b1;
    repeat (3) tick;
    ack = 2'b00;
    chk("pd_tag_busy", fill_busy, 1);
    tick;
    chk("pd_idle_busy", fill_busy, 0);
    chk("pd_idle_flag", icu_in_powerdown, 0);
    tick;
    chk("pd_enter_flag", icu_in_powerdown, 0);
    chk("pd_enter_req", icu_req, 0);
    tick;
    chk("pd_flag", icu_in_powerdown, 1);
    chk("pd_busy", fill_busy, 0);
    exp_req(32'h0000_3000, 4'b0000, 2'b10);
    exp_ev(2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    miss_addr      = 32'h0000_3000;
    iu_psr_ice     = 1'b0;
    pcsu_powerdown = 1'b0;
    tick;
    chk("pd_exit_flag", icu_in_powerdown, 0);
    chk("pd_exit_req", icu_req, 0);
    tick;
    chk("pd_miss_accept", icu_req, 1);
    miss_req = 1'b0;
    ack = 2'b01;
    tick;
    ack = 2'b00;
    chk("pd_miss_done", fill_busy, 0);

    repeat (2) tick;
    chk("ev_queue_drained", ev_q.size(), 0);
    chk("req_queue_drained", req_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
